// File: rtl/sample_encoder.sv
// -----------------------------------------------------------------------------
// sample_encoder
//
// Transmit-side oversampling encoder. A code word accepted over a valid/ready
// handshake is serialised LSB first, each bit held on tx_bit for
// SAMPLES_PER_BIT sample periods of CLKS_PER_SAMPLE clocks each. sample_flag
// is high for the whole frame; the far-end decoder votes on its falling edge.
// After every frame the line rests low for IDLE_GAP sample periods before the
// next code can be accepted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   code         code word to transmit
//   code_valid   code is valid this cycle
//   code_ready   encoder accepts a code this cycle (registered)
//   tx_bit       serial oversampled line value (registered)
//   sample_flag  high for the full duration of a frame (registered)
//   frame_done   one-cycle pulse as the last sample period ends (registered)
// -----------------------------------------------------------------------------
module sample_encoder #(
   parameter int CODE_WIDTH      = 8,
   parameter int SAMPLES_PER_BIT = 10,
   parameter int CLKS_PER_SAMPLE = 1,
   parameter int IDLE_GAP        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CODE_WIDTH-1:0] code,
   input  logic                  code_valid,
   output logic                  code_ready,
   output logic                  tx_bit,
   output logic                  sample_flag,
   output logic                  frame_done
);

   // Each counter only has to reach its terminal value, never beyond it.
   localparam int DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam int SMP_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
   localparam int BIT_W = (CODE_WIDTH > 1)      ? $clog2(CODE_WIDTH)      : 1;
   localparam int GAP_W = (IDLE_GAP > 1)        ? $clog2(IDLE_GAP)        : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CODE_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                  state_r;
   logic [CODE_WIDTH-1:0]   held_code_r;
   logic [DIV_W-1:0]        div_cnt_r;
   logic [SMP_W-1:0]        sample_cnt_r;
   logic [BIT_W-1:0]        bit_idx_r;
   logic [GAP_W-1:0]        gap_cnt_r;
   logic                    code_ready_r;
   logic                    tx_bit_r;
   logic                    sample_flag_r;
   logic                    frame_done_r;

   logic                    tick_s;
   logic [BIT_W-1:0]        bit_next_s;

   // Sample tick: divider terminal count; also the index of the next code bit.
   always_comb begin
      tick_s     = (div_cnt_r == DIV_LAST);
      bit_next_s = bit_idx_r + BIT_W'(1);
   end

   // Frame sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         held_code_r   <= '0;
         div_cnt_r     <= '0;
         sample_cnt_r  <= '0;
         bit_idx_r     <= '0;
         gap_cnt_r     <= '0;
         code_ready_r  <= 1'b0;
         tx_bit_r      <= 1'b0;
         sample_flag_r <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               frame_done_r <= 1'b0;
               if (code_valid && code_ready_r) begin
                  // First sample of bit 0 is on the line right after acceptance.
                  held_code_r   <= code;
                  div_cnt_r     <= '0;
                  sample_cnt_r  <= '0;
                  bit_idx_r     <= '0;
                  gap_cnt_r     <= '0;
                  state_r       <= ST_SEND;
                  code_ready_r  <= 1'b0;
                  sample_flag_r <= 1'b1;
                  tx_bit_r      <= code[0];
               end else begin
                  code_ready_r  <= 1'b1;
                  sample_flag_r <= 1'b0;
                  tx_bit_r      <= 1'b0;
               end
            end

            ST_SEND: begin
               frame_done_r <= 1'b0;
               code_ready_r <= 1'b0;
               if (tick_s) begin
                  div_cnt_r <= '0;
                  if (sample_cnt_r == SMP_LAST) begin
                     sample_cnt_r <= '0;
                     if (bit_idx_r == BIT_LAST) begin
                        // Last sample period of the frame has just ended.
                        state_r       <= ST_GAP;
                        bit_idx_r     <= '0;
                        gap_cnt_r     <= '0;
                        sample_flag_r <= 1'b0;
                        tx_bit_r      <= 1'b0;
                        frame_done_r  <= 1'b1;
                     end else begin
                        bit_idx_r <= bit_next_s;
                        tx_bit_r  <= held_code_r[bit_next_s];
                     end
                  end else begin
                     sample_cnt_r <= sample_cnt_r + SMP_W'(1);
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_W'(1);
               end
            end

            ST_GAP: begin
               frame_done_r  <= 1'b0;
               sample_flag_r <= 1'b0;
               tx_bit_r      <= 1'b0;
               if (tick_s) begin
                  div_cnt_r <= '0;
                  if (gap_cnt_r == GAP_LAST) begin
                     // Ready is raised here so IDLE can accept on its first cycle.
                     state_r      <= ST_IDLE;
                     gap_cnt_r    <= '0;
                     code_ready_r <= 1'b1;
                  end else begin
                     gap_cnt_r    <= gap_cnt_r + GAP_W'(1);
                     code_ready_r <= 1'b0;
                  end
               end else begin
                  div_cnt_r    <= div_cnt_r + DIV_W'(1);
                  code_ready_r <= 1'b0;
               end
            end

            default: begin
               state_r       <= ST_IDLE;
               div_cnt_r     <= '0;
               sample_cnt_r  <= '0;
               bit_idx_r     <= '0;
               gap_cnt_r     <= '0;
               code_ready_r  <= 1'b0;
               tx_bit_r      <= 1'b0;
               sample_flag_r <= 1'b0;
               frame_done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign code_ready  = code_ready_r;
   assign tx_bit      = tx_bit_r;
   assign sample_flag = sample_flag_r;
   assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_sample_encoder.sv
// -----------------------------------------------------------------------------
// tb_sample_encoder
//
// Bench for sample_encoder. A default-parameter instance is driven from a
// table of code words plus hand-written sequences (back-to-back, ignored
// valid, mid-frame reset); each accepted code is queued as the expected
// frame and a negedge monitor rebuilds every frame from tx_bit, votes it back
// into a code word and compares. A second instance with CLKS_PER_SAMPLE=4
// checks the stretched timing.
// -----------------------------------------------------------------------------
module tb_sample_encoder;

   typedef struct {
      logic [7:0] code;
      int         ones;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       tx_bit;
   logic       sample_flag;
   logic       frame_done;

   logic [7:0] c4_code;
   logic       c4_valid;
   logic       c4_ready;
   logic       c4_tx;
   logic       c4_flag;
   logic       c4_done;

   int   total = 0;
   int   bad   = 0;
   int   done_cnt = 0;
   vec_t exp_q[$];

   sample_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .code        (code),
      .code_valid  (code_valid),
      .code_ready  (code_ready),
      .tx_bit      (tx_bit),
      .sample_flag (sample_flag),
      .frame_done  (frame_done)
   );

   sample_encoder #(.CLKS_PER_SAMPLE(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .code        (c4_code),
      .code_valid  (c4_valid),
      .code_ready  (c4_ready),
      .tx_bit      (c4_tx),
      .sample_flag (c4_flag),
      .frame_done  (c4_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Loopback receiver: shift register of samples, decoded on sample_flag fall.
   logic samples [0:127];
   int   nsamp     = 0;
   logic prev_flag = 1'b0;

   task automatic end_frame();
      vec_t       e;
      logic [7:0] dec;
      int         ones;
      int         exact_err;
      int         vote;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("frame_len", 32'(nsamp), 32'd80);
         ones = 0;
         exact_err = 0;
         for (int k = 0; k < 80; k++) begin
            if (samples[k] === 1'b1) ones++;
            if (samples[k] !== e.code[k / 10]) exact_err++;
         end
         for (int b = 0; b < 8; b++) begin
            vote = 0;
            for (int s = 0; s < 10; s++) begin
               if (samples[b * 10 + s] === 1'b1) vote++;
            end
            dec[b] = (vote > 5);
         end
         chk("decode", {24'd0, dec}, {24'd0, e.code});
         chk("ones", 32'(ones), 32'(e.ones));
         chk("sample_order", 32'(exact_err), 32'd0);
      end
   endtask

   // Monitor for the default instance, sampling away from the rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         nsamp     = 0;
         prev_flag = 1'b0;
      end else begin
         if (frame_done === 1'b1) done_cnt++;
         if (prev_flag && !sample_flag) begin
            chk("done_at_fall", {31'd0, frame_done}, 32'd1);
            end_frame();
            nsamp = 0;
         end else if (frame_done === 1'b1) begin
            chk("done_without_fall", 32'd1, 32'd0);
         end
         if (sample_flag === 1'b1) begin
            if (nsamp < 128) samples[nsamp] = tx_bit;
            nsamp++;
         end
         prev_flag = sample_flag;
      end
   end

   task automatic send_code(input logic [7:0] c, input int ones);
      int t;
      t = 0;
      code = c;
      code_valid = 1'b1;
      while (code_ready !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (code_ready !== 1'b1) begin
         chk("accept_timeout", 32'd0, 32'd1);
         code_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         code_valid = 1'b0;
         exp_q.push_back('{c, ones});
      end
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      @(negedge clk);
      while (frame_done !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", {31'd0, frame_done}, 32'd1);
   endtask

   vec_t vecs [6];

   initial begin
      int gap;
      int hi;
      int txerr;
      int t;
      int dc;

      vecs[0] = '{8'hA5, 40};
      vecs[1] = '{8'h00, 0};
      vecs[2] = '{8'hFF, 80};
      vecs[3] = '{8'h5A, 40};
      vecs[4] = '{8'h81, 20};
      vecs[5] = '{8'h0F, 40};

      rst_n = 1'b0;
      code = 8'h00;
      code_valid = 1'b0;
      c4_code = 8'h00;
      c4_valid = 1'b0;

      // Reset state.
      #3;
      chk("rst_ready", {31'd0, code_ready}, 32'd0);
      chk("rst_tx", {31'd0, tx_bit}, 32'd0);
      chk("rst_flag", {31'd0, sample_flag}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", {31'd0, code_ready}, 32'd0);
      @(negedge clk);
      chk("ready_first_edge", {31'd0, code_ready}, 32'd1);

      // Table of single frames.
      for (int i = 0; i < 6; i++) begin
         send_code(vecs[i].code, vecs[i].ones);
         wait_done();
      end

      // Back-to-back with valid held; code changes right after acceptance.
      @(negedge clk);
      code = 8'h3C;
      code_valid = 1'b1;
      t = 0;
      while (code_ready !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      code = 8'hC3;
      exp_q.push_back('{8'h3C, 40});
      exp_q.push_back('{8'hC3, 40});
      wait_done();
      gap = 0;
      while (sample_flag !== 1'b1 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      code_valid = 1'b0;
      chk("b2b_gap", 32'(gap), 32'd3);
      wait_done();

      // Valid pulses during SEND and GAP are ignored.
      @(negedge clk);
      send_code(8'h69, 40);
      repeat (20) @(negedge clk);
      code = 8'hFF;
      code_valid = 1'b1;
      chk("ready_in_send", {31'd0, code_ready}, 32'd0);
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      wait_done();
      code = 8'h00;
      code_valid = 1'b1;
      chk("ready_in_gap", {31'd0, code_ready}, 32'd0);
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      @(negedge clk);
      chk("ready_gap_end", {31'd0, code_ready}, 32'd0);
      @(negedge clk);
      chk("ready_idle", {31'd0, code_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("no_spurious_frame", {31'd0, sample_flag}, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a frame.
      send_code(8'hFF, 80);
      repeat (37) @(negedge clk);
      #1;
      chk("pre_abort_tx", {31'd0, tx_bit}, 32'd1);
      chk("pre_abort_flag", {31'd0, sample_flag}, 32'd1);
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_tx", {31'd0, tx_bit}, 32'd0);
      chk("abort_flag", {31'd0, sample_flag}, 32'd0);
      chk("abort_ready", {31'd0, code_ready}, 32'd0);
      chk("abort_done", {31'd0, frame_done}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("no_done_after_abort", 32'(done_cnt - dc), 32'd0);
      send_code(8'h0F, 40);
      wait_done();
      repeat (4) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      // Four clocks per sample period.
      c4_code = 8'h01;
      c4_valid = 1'b1;
      t = 0;
      while (c4_ready !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      c4_valid = 1'b0;
      c4_code = 8'hFF;
      @(negedge clk);
      hi = 0;
      txerr = 0;
      while (c4_flag === 1'b1 && hi < 1000) begin
         hi++;
         if (c4_tx !== ((hi <= 40) ? 1'b1 : 1'b0)) txerr++;
         @(negedge clk);
      end
      chk("c4_flag_len", 32'(hi), 32'd320);
      chk("c4_tx_pattern", 32'(txerr), 32'd0);
      chk("c4_done", {31'd0, c4_done}, 32'd1);
      gap = 0;
      while (c4_ready !== 1'b1 && gap < 100) begin
         gap++;
         @(negedge clk);
      end
      chk("c4_gap_len", 32'(gap), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample_encoder.md
Name: sample_encoder

Overview:
- Transmit-side counterpart of the receiver's majority-vote sample decoder.
- Accepts an 8-bit code over a valid/ready handshake and serialises it as an oversampled frame: each code bit is driven for SAMPLES_PER_BIT consecutive sample periods, LSB first.
- A frame-envelope flag (sample_flag) brackets each frame. The receiver decodes on sample_flag's falling edge.
- Sits between the TX data source and the line driver / loopback path.

Parameters:
- CODE_WIDTH, 8, bits per code word.
- SAMPLES_PER_BIT, 10, sample periods per code bit.
- CLKS_PER_SAMPLE, 1, clk cycles per sample period (must be >= 1).
- IDLE_GAP, 2, sample periods with sample_flag low between frames (must be >= 1).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- code, input, CODE_WIDTH, code word to transmit.
- code_valid, input, 1, code is valid this cycle.
- code_ready, output, 1, encoder can accept a code this cycle.
- tx_bit, output, 1, serial oversampled line value.
- sample_flag, output, 1, high for the full duration of a frame.
- frame_done, output, 1, one-cycle pulse when a frame's last sample period ends.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous) forces:
  - state IDLE and all counters 0;
  - code_ready=0, tx_bit=0, sample_flag=0, frame_done=0.
- code_ready rises on the first rising clk edge with rst_n high.
- Reset asserted mid-frame aborts the frame immediately; no frame_done is generated.
- States:
  - IDLE: code_ready=1, sample_flag=0, tx_bit=0.
    - On a clk edge with code_valid && code_ready: latch code into a shift/hold register, clear counters, go to SEND.
    - Effects visible after that same edge: code_ready=0, sample_flag=1, tx_bit=code[0].
    - Acceptance-to-first-sample latency: 1 cycle.
  - SEND: tx_bit = held_code[bit_idx].
    - A clock divider counts 0..CLKS_PER_SAMPLE-1. Its terminal count is a sample tick.
    - On each tick, sample_cnt increments.
    - When sample_cnt reaches SAMPLES_PER_BIT-1 on a tick, it wraps to 0 and bit_idx increments.
    - On the tick where bit_idx=CODE_WIDTH-1 and sample_cnt=SAMPLES_PER_BIT-1:
      - go to GAP;
      - sample_flag=0, tx_bit=0, frame_done=1 for exactly one cycle.
    - SEND lasts exactly CODE_WIDTH*SAMPLES_PER_BIT*CLKS_PER_SAMPLE cycles (80 at defaults).
  - GAP: sample_flag=0, tx_bit=0, code_ready=0.
    - Lasts IDLE_GAP sample periods (IDLE_GAP*CLKS_PER_SAMPLE cycles), then IDLE with code_ready=1.
- Sample ordering: sample period k of a frame (k=0 first) carries bit floor(k/SAMPLES_PER_BIT). It therefore lands at receiver sample index k, which the decoder votes into code bit floor(k/10).
- Handshake rules:
  - code_valid while code_ready=0 is ignored. The source must hold it until accepted.
  - Changes on code after acceptance do not affect the frame in flight.
  - code_valid held continuously gives back-to-back frames separated by exactly IDLE_GAP sample periods plus 1 cycle (the IDLE acceptance cycle).
- Counter widths: sized via $clog2 of their terminal count, minimum 1 bit. No overflow is possible because every counter wraps at its terminal value.

Test Plan:
- Reset then single frame: release rst_n, present code=8'hA5 with code_valid=1.
  - Accepted on the first edge where code_ready=1.
  - sample_flag high for exactly 80 cycles.
  - tx_bit pattern: 10×1, 10×0, 10×1, 10×0, 10×0, 10×1, 10×0, 10×1.
  - frame_done pulses once when sample_flag falls.
- Loopback: drive tx_bit into an 80-bit shift register (first sample into index 0), pulse sample_flag into the decoder.
  - Codes 8'h00, 8'hFF, 8'h5A, 8'h81 decode identically.
- Back-to-back with code_valid held high, codes 8'h3C then 8'hC3:
  - 3-cycle gap (IDLE_GAP=2 plus 1 cycle) between sample_flag fall and the next rise.
  - Second frame correct; code changed mid-frame has no effect.
- CLKS_PER_SAMPLE=4, code=8'h01:
  - sample_flag high for 320 cycles.
  - tx_bit high for the first 40 cycles, low for the remainder.
  - GAP lasts 8 cycles.
- Reset mid-frame: assert rst_n low at cycle 37 of SEND.
  - tx_bit, sample_flag and code_ready go 0 immediately, without waiting for a clk edge.
  - No frame_done.
  - After release, the next code 8'h0F transmits cleanly.
- Ignored valid: pulse code_valid during SEND and during GAP.
  - No acceptance; the frame in flight is unchanged; code_ready stays 0 until IDLE.
